// File: rtl/clk_meter_pkg.sv
// clk_meter_pkg
// Shared types and helpers for the toggle-frequency meter:
//   meter_state_t  - IDLE / GATE / HOLD measurement sequencer states
//   gate_cnt_width - width of the gate-window down-counter for a given window
package clk_meter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        HOLD = 2'd2
    } meter_state_t;

    // The counter is loaded with GATE_CYCLES-1 and counts down to 0, so
    // $clog2(GATE_CYCLES) bits are enough. Clamp to 1 bit for degenerate inputs.
    function automatic int gate_cnt_width(input int gate_cycles);
        if (gate_cycles < 2) begin
            return 1;
        end
        return $clog2(gate_cycles);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det
// Brings an asynchronous toggle signal into the clk domain through a
// SYNC_STAGES flip-flop chain, keeps one history flop behind the chain and
// flags a rising edge for one cycle.
// Ports:
//   clk     in  fabric clock
//   rst     in  synchronous active-high reset, clears chain and history
//   meas_in in  asynchronous signal under measurement
//   rise    out high for one cycle per synchronized rising edge
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic meas_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   hist_reg;

    // First stage samples the asynchronous input; later stages only resolve
    // metastability, so each just copies its predecessor.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg[0] <= 1'b0;
        end else begin
            sync_reg[0] <= meas_in;
        end
    end

    generate
        for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge clk) begin
                if (rst) begin
                    sync_reg[gi] <= 1'b0;
                end else begin
                    sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_reg <= 1'b0;
        end else begin
            hist_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign rise = sync_reg[SYNC_STAGES-1] & ~hist_reg;

endmodule

// File: rtl/clk_toggle_meter.sv
// clk_toggle_meter
// Counts rising edges of an asynchronous heartbeat over a window of
// GATE_CYCLES clk cycles and presents the count through a valid/ready result.
// Ports:
//   clk          in  fabric clock (125 MHz nominal)
//   rst          in  synchronous active-high reset
//   meas_in      in  asynchronous toggle signal under measurement
//   start        in  request one measurement (honoured only when idle)
//   auto_rearm   in  start the next window right after each result handshake
//   busy         out high while gating or holding a result
//   result_valid out edge_count/overflow hold a result
//   result_ready in  consumer accepts the result
//   edge_count   out rising edges seen in the last window (saturating)
//   overflow     out edge counter saturated during the last window
module clk_toggle_meter
    import clk_meter_pkg::*;
#(
    parameter int GATE_CYCLES = 125_000_000,
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             meas_in,
    input  logic             start,
    input  logic             auto_rearm,
    output logic             busy,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [CNT_W-1:0] edge_count,
    output logic             overflow
);

    localparam int             GCW       = gate_cnt_width(GATE_CYCLES);
    localparam logic [GCW-1:0] GATE_LOAD = GCW'(GATE_CYCLES - 1);

    meter_state_t     state_reg, state_next;
    logic [GCW-1:0]   gate_cnt_reg;
    logic [CNT_W-1:0] acc_reg;
    logic             ovf_reg;
    logic             busy_reg, busy_next;
    logic             valid_reg, valid_next;
    logic [CNT_W-1:0] edge_count_reg;
    logic             overflow_reg;

    logic             rise;
    logic             acc_full;
    logic             sat_hit;
    logic [CNT_W-1:0] acc_next;
    logic             gate_last;
    logic             handshake;
    logic             load_gate;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge_det (
        .clk     (clk),
        .rst     (rst),
        .meas_in (meas_in),
        .rise    (rise)
    );

    // Saturating increment: a rise at all-ones leaves acc alone and is
    // remembered as overflow instead.
    assign acc_full  = &acc_reg;
    assign sat_hit   = rise & acc_full;
    assign acc_next  = acc_reg + CNT_W'(rise & ~acc_full);

    assign gate_last = (state_reg == GATE) && (gate_cnt_reg == '0);
    assign handshake = (state_reg == HOLD) && valid_reg && result_ready;
    // Both a start from IDLE and an auto-rearm handshake open a fresh window.
    assign load_gate = ((state_reg == IDLE) && start) || (handshake && auto_rearm);

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = GATE;
                end
            end
            GATE: begin
                if (gate_last) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (handshake) begin
                    state_next = auto_rearm ? GATE : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    // Decoded from the next state so the registered flags line up with the
    // state they describe.
    always_comb begin
        busy_next  = (state_next != IDLE);
        valid_next = (state_next == HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_reg  <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            busy_reg  <= busy_next;
            valid_reg <= valid_next;
        end
    end

    // ---------------- gate counter, accumulator, result ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            gate_cnt_reg   <= '0;
            acc_reg        <= '0;
            ovf_reg        <= 1'b0;
            edge_count_reg <= '0;
            overflow_reg   <= 1'b0;
        end else if (load_gate) begin
            gate_cnt_reg <= GATE_LOAD;
            acc_reg      <= '0;
            ovf_reg      <= 1'b0;
        end else if (state_reg == GATE) begin
            gate_cnt_reg <= gate_cnt_reg - GCW'(1);
            acc_reg      <= acc_next;
            ovf_reg      <= ovf_reg | sat_hit;
            // The final gate cycle's rise is folded straight into the result.
            if (gate_last) begin
                edge_count_reg <= acc_next;
                overflow_reg   <= ovf_reg | sat_hit;
            end
        end
    end

    assign busy         = busy_reg;
    assign result_valid = valid_reg;
    assign edge_count   = edge_count_reg;
    assign overflow     = overflow_reg;

endmodule

// File: tb/tb_clk_toggle_meter.sv
// tb_clk_toggle_meter
// Directed bench for clk_toggle_meter with a 100-cycle gate window. A 32-bit
// instance covers counting, backpressure, reset and auto-rearm; a 4-bit
// instance covers counter saturation.
module tb_clk_toggle_meter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        meas_in = 1'b0;
    logic        start = 1'b0;
    logic        auto_rearm = 1'b0;
    logic        result_ready = 1'b0;
    logic        busy;
    logic        result_valid;
    logic [31:0] edge_count;
    logic        overflow;

    logic        s_meas = 1'b0;
    logic        s_start = 1'b0;
    logic        s_ready = 1'b0;
    logic        s_busy;
    logic        s_valid;
    logic [3:0]  s_count;
    logic        s_ovf;

    int total = 0;
    int bad = 0;
    int mode = 0;   // 0: period-10 toggle, 1: constant 1, 2: constant 0

    always #4 clk = ~clk;

    clk_toggle_meter #(
        .GATE_CYCLES (100),
        .CNT_W       (32),
        .SYNC_STAGES (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .meas_in      (meas_in),
        .start        (start),
        .auto_rearm   (auto_rearm),
        .busy         (busy),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .edge_count   (edge_count),
        .overflow     (overflow)
    );

    clk_toggle_meter #(
        .GATE_CYCLES (100),
        .CNT_W       (4),
        .SYNC_STAGES (2)
    ) dut4 (
        .clk          (clk),
        .rst          (rst),
        .meas_in      (s_meas),
        .start        (s_start),
        .auto_rearm   (1'b0),
        .busy         (s_busy),
        .result_valid (s_valid),
        .result_ready (s_ready),
        .edge_count   (s_count),
        .overflow     (s_ovf)
    );

    // Input generators, driven on the falling edge.
    initial begin
        int ph = 0;
        forever begin
            @(negedge clk);
            ph = (ph + 1) % 10;
            case (mode)
                0:       meas_in = (ph < 5);
                1:       meas_in = 1'b1;
                default: meas_in = 1'b0;
            endcase
            s_meas = ~s_meas;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Full measurement with ready low until the result appears, then one
    // handshake cycle.
    task automatic run_measure(input string tag, input logic [31:0] exp_cnt);
        pulse_start();
        repeat (99) step();
        check({tag, "_valid_early"}, 64'(result_valid), 64'd0);
        check({tag, "_busy_gate"}, 64'(busy), 64'd1);
        step();
        check({tag, "_valid"}, 64'(result_valid), 64'd1);
        check({tag, "_count"}, 64'(edge_count), 64'(exp_cnt));
        check({tag, "_ovf"}, 64'(overflow), 64'd0);
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        check({tag, "_valid_drop"}, 64'(result_valid), 64'd0);
        check({tag, "_busy_drop"}, 64'(busy), 64'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) step();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(result_valid), 64'd0);
        check("rst_count", 64'(edge_count), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        rst = 1'b0;
        repeat (2) step();
        check("idle_busy", 64'(busy), 64'd0);

        // Period-10 toggle: 10 rises in any 100-cycle window
        run_measure("p10", 32'd10);
        $display("txn p10 count=%0d ovf=%0b", edge_count, overflow);

        // Constant inputs
        mode = 1;
        repeat (5) step();
        run_measure("const1", 32'd0);
        $display("txn const1 count=%0d", edge_count);
        mode = 2;
        repeat (5) step();
        run_measure("const0", 32'd0);
        $display("txn const0 count=%0d", edge_count);
        mode = 0;
        repeat (5) step();

        // Saturation on the 4-bit instance: 50 rises clip at 15
        s_start = 1'b1;
        step();
        s_start = 1'b0;
        repeat (99) step();
        check("sat_valid_early", 64'(s_valid), 64'd0);
        step();
        check("sat_valid", 64'(s_valid), 64'd1);
        check("sat_count", 64'(s_count), 64'd15);
        check("sat_ovf", 64'(s_ovf), 64'd1);
        $display("txn sat count=%0d ovf=%0b", s_count, s_ovf);
        s_ready = 1'b1;
        step();
        s_ready = 1'b0;
        check("sat_valid_drop", 64'(s_valid), 64'd0);

        // Backpressure: result held, start ignored while holding
        pulse_start();
        repeat (100) step();
        check("bp_valid", 64'(result_valid), 64'd1);
        for (int i = 0; i < 30; i++) begin
            start = (i == 10);
            step();
            check("bp_hold", {28'd0, result_valid, busy, overflow, edge_count},
                  {28'd0, 1'b1, 1'b1, 1'b0, 32'd10});
        end
        start = 1'b0;
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        check("bp_valid_drop", 64'(result_valid), 64'd0);
        check("bp_busy_drop", 64'(busy), 64'd0);
        repeat (3) step();
        check("bp_start_ignored", 64'(busy), 64'd0);
        $display("txn backpressure count=%0d", edge_count);

        // Reset in gate cycle 50
        pulse_start();
        repeat (49) step();
        check("mid_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        step();
        check("mid_rst_outs", {busy, result_valid, overflow, edge_count}, 35'd0);
        rst = 1'b0;
        repeat (3) step();
        check("mid_idle", 64'(busy), 64'd0);
        run_measure("after_rst", 32'd10);
        $display("txn reset_midgate fresh count=%0d", edge_count);

        // Auto-rearm with ready tied high: valid one cycle in every 101
        auto_rearm = 1'b1;
        result_ready = 1'b1;
        pulse_start();
        for (int n = 1; n <= 305; n++) begin
            logic exp_v;
            step();
            exp_v = (n == 100) || (n == 201) || (n == 302);
            check("ar_busy_valid", {62'd0, busy, result_valid}, {62'd0, 1'b1, exp_v});
            if (exp_v) begin
                check("ar_count", 64'(edge_count), 64'd10);
                $display("txn auto_rearm n=%0d count=%0d", n, edge_count);
            end
        end
        auto_rearm = 1'b0;
        repeat (110) step();
        check("ar_stop_idle", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
